// File: rtl/xy_sample_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xy_sample_buffer_pkg
//  Description : Shared scope constants and capture-buffer state encoding,
//                used by both the sample buffer and the curve stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package xy_sample_buffer_pkg;

   // Shared sample / address geometry between capture and curve stages
   localparam int c_DATA_IN_BITS = 12;
   localparam int c_ADDRESS_BITS = 12;
   localparam int c_DEPTH        = 1024;

   // Capture-side state: filling the write bank, or holding a full frame
   typedef enum logic [0:0] {
      FILL = 1'b0,
      FULL = 1'b1
   } bufState_t;

   // Address width needed to index a RAM of the given depth (at least 1)
   function automatic int ramAddrBits(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sample_bank_ram.sv
`default_nettype none
// ============================================================================
//  Module      : sample_bank_ram
//  Description : Single-bank sample store, one write port and one registered
//                read port. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_bank_ram
   import xy_sample_buffer_pkg::*;
#(
   parameter int DATA_BITS = c_DATA_IN_BITS,
   parameter int DEPTH     = c_DEPTH,
   parameter int ADDR_BITS = ramAddrBits(DEPTH)
) (
   input  logic                 clock,
   input  logic                 writeEnable,
   input  logic [ADDR_BITS-1:0] writeAddress,
   input  logic [DATA_BITS-1:0] writeData,
   input  logic [ADDR_BITS-1:0] readAddress,
   output logic [DATA_BITS-1:0] readData
);

   logic [DATA_BITS-1:0] r_mem [DEPTH];

   // Synchronous write and registered read
   always_ff @(posedge clock) begin
      if (writeEnable) begin
         r_mem[writeAddress] <= writeData;
      end
      readData <= r_mem[readAddress];
   end

endmodule
`default_nettype wire

// File: rtl/xy_sample_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : xy_sample_buffer
//  Description : Ping-pong X/Y sample frame buffer between the capture path
//                and the curve drawing stage, with decimation and overrun
//                reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module xy_sample_buffer
   import xy_sample_buffer_pkg::*;
#(
   parameter int DATA_IN_BITS  = c_DATA_IN_BITS,
   parameter int ADDRESS_BITS  = c_ADDRESS_BITS,
   parameter int DEPTH         = c_DEPTH,
   parameter int DECIMATE_BITS = 8
) (
   input  logic                            clock,
   input  logic                            reset_n,
   input  logic                            sampleValid,
   input  logic signed [DATA_IN_BITS-1:0]  sample1,
   input  logic signed [DATA_IN_BITS-1:0]  sample2,
   input  logic        [DECIMATE_BITS-1:0] decimation,
   input  logic                            drawStarting,
   input  logic        [ADDRESS_BITS-1:0]  address1,
   input  logic        [ADDRESS_BITS-1:0]  address2,
   output logic signed [DATA_IN_BITS-1:0]  dataOut1,
   output logic signed [DATA_IN_BITS-1:0]  dataOut2,
   output logic                            frameReady,
   output logic                            overrun
);

   localparam int                      c_RAM_AW    = ramAddrBits(DEPTH);
   localparam logic [ADDRESS_BITS-1:0] c_LAST_ADDR = ADDRESS_BITS'(DEPTH - 1);
   localparam logic [ADDRESS_BITS:0]   c_DEPTH_EXT = (ADDRESS_BITS + 1)'(DEPTH);

   bufState_t                 r_state;
   bufState_t                 w_stateNext;
   logic [ADDRESS_BITS-1:0]   r_wrAddr;
   logic [DECIMATE_BITS-1:0]  r_decCount;
   logic                      r_readBank;
   logic                      r_frameValid;
   logic                      r_overrun;
   logic                      r_rdSel;
   logic                      r_rdOk1;
   logic                      r_rdOk2;

   logic                      w_storeSample;
   logic                      w_swap;
   logic                      w_write;
   logic                      w_lastWrite;

   logic [DATA_IN_BITS-1:0]   w_rdData1 [2];
   logic [DATA_IN_BITS-1:0]   w_rdData2 [2];

   assign w_storeSample = sampleValid && (r_decCount == decimation);
   assign w_swap        = (r_state == FULL) && drawStarting;
   assign w_write       = (r_state == FILL) && w_storeSample;
   assign w_lastWrite   = w_write && (r_wrAddr == c_LAST_ADDR);

   // Capture state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= FILL;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next state: full on the last write, back to filling on a swap
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         FILL:    if (w_lastWrite)  w_stateNext = FULL;
         FULL:    if (drawStarting) w_stateNext = FILL;
         default: w_stateNext = FILL;
      endcase
   end

   // Write pointer, decimation counter, bank select and status flags; a swap
   // takes priority over any sample arriving in the same cycle
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wrAddr     <= '0;
         r_decCount   <= '0;
         r_readBank   <= 1'b0;
         r_frameValid <= 1'b0;
         r_overrun    <= 1'b0;
      end else if (w_swap) begin
         r_wrAddr     <= '0;
         r_decCount   <= '0;
         r_readBank   <= ~r_readBank;
         r_frameValid <= 1'b1;
         r_overrun    <= 1'b0;
      end else begin
         if (sampleValid) begin
            r_decCount <= w_storeSample ? '0 : r_decCount + 1'b1;
         end
         if (w_write && !w_lastWrite) begin
            r_wrAddr <= r_wrAddr + 1'b1;
         end
         if ((r_state == FULL) && w_storeSample) begin
            r_overrun <= 1'b1;
         end
      end
   end

   // Read qualifiers travel alongside the RAM read so a swap-cycle read
   // still selects the old bank
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rdSel <= 1'b0;
         r_rdOk1 <= 1'b0;
         r_rdOk2 <= 1'b0;
      end else begin
         r_rdSel <= r_readBank;
         r_rdOk1 <= r_frameValid && ({1'b0, address1} < c_DEPTH_EXT);
         r_rdOk2 <= r_frameValid && ({1'b0, address2} < c_DEPTH_EXT);
      end
   end

   // Two banks per channel; the bank not selected for reading takes writes
   for (genvar b = 0; b < 2; b++) begin : g_bank
      logic w_bankWrite;
      assign w_bankWrite = w_write && (r_readBank != 1'(b));

      sample_bank_ram #(
         .DATA_BITS (DATA_IN_BITS),
         .DEPTH     (DEPTH),
         .ADDR_BITS (c_RAM_AW)
      ) u_ramCh1 (
         .clock        (clock),
         .writeEnable  (w_bankWrite),
         .writeAddress (r_wrAddr[c_RAM_AW-1:0]),
         .writeData    (sample1),
         .readAddress  (address1[c_RAM_AW-1:0]),
         .readData     (w_rdData1[b])
      );

      sample_bank_ram #(
         .DATA_BITS (DATA_IN_BITS),
         .DEPTH     (DEPTH),
         .ADDR_BITS (c_RAM_AW)
      ) u_ramCh2 (
         .clock        (clock),
         .writeEnable  (w_bankWrite),
         .writeAddress (r_wrAddr[c_RAM_AW-1:0]),
         .writeData    (sample2),
         .readAddress  (address2[c_RAM_AW-1:0]),
         .readData     (w_rdData2[b])
      );
   end

   assign dataOut1   = r_rdOk1 ? w_rdData1[r_rdSel] : '0;
   assign dataOut2   = r_rdOk2 ? w_rdData2[r_rdSel] : '0;
   assign frameReady = (r_state == FULL);
   assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_xy_sample_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xy_sample_buffer
//  Description : Directed, table-driven bench for xy_sample_buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xy_sample_buffer;

   logic              clock = 1'b0;
   logic              reset_n;
   logic              sampleValid;
   logic signed [11:0] sample1;
   logic signed [11:0] sample2;
   logic [7:0]        decimation;
   logic              drawStarting;
   logic [11:0]       address1;
   logic [11:0]       address2;
   logic signed [11:0] dataOut1;
   logic signed [11:0] dataOut2;
   logic              frameReady;
   logic              overrun;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int    a1;
      int    a2;
      int    e1;
      int    e2;
      string tag;
   } rdVec_t;

   rdVec_t vecs[$];

   always #5 clock = ~clock;

   xy_sample_buffer dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .sampleValid  (sampleValid),
      .sample1      (sample1),
      .sample2      (sample2),
      .decimation   (decimation),
      .drawStarting (drawStarting),
      .address1     (address1),
      .address2     (address2),
      .dataOut1     (dataOut1),
      .dataOut2     (dataOut2),
      .frameReady   (frameReady),
      .overrun      (overrun)
   );

   task automatic check(input string name, input logic signed [31:0] act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int s12(input int v);
      logic signed [11:0] t;
      t = v[11:0];
      return int'(t);
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pushPair(input int s1, input int s2, input logic draw);
      sampleValid  = 1'b1;
      sample1      = s1[11:0];
      sample2      = s2[11:0];
      drawStarting = draw;
      tick();
      sampleValid  = 1'b0;
      drawStarting = 1'b0;
   endtask

   task automatic drawPulse();
      drawStarting = 1'b1;
      tick();
      drawStarting = 1'b0;
   endtask

   task automatic addVec(input int a1, input int a2, input int e1, input int e2, input string tag);
      rdVec_t v;
      v.a1 = a1; v.a2 = a2; v.e1 = e1; v.e2 = e2; v.tag = tag;
      vecs.push_back(v);
   endtask

   task automatic runVecs();
      foreach (vecs[i]) begin
         address1 = 12'(vecs[i].a1);
         address2 = 12'(vecs[i].a2);
         tick();
         check({vecs[i].tag, "_d1"}, dataOut1, vecs[i].e1);
         check({vecs[i].tag, "_d2"}, dataOut2, vecs[i].e2);
      end
      vecs.delete();
   endtask

   initial begin
      reset_n      = 1'b1;
      sampleValid  = 1'b0;
      sample1      = '0;
      sample2      = '0;
      decimation   = '0;
      drawStarting = 1'b0;
      address1     = '0;
      address2     = '0;
      #2 reset_n   = 1'b0;
      repeat (3) tick();
      check("rst_d1", dataOut1, 0);
      check("rst_d2", dataOut2, 0);
      check("rst_frameReady", frameReady, 0);
      check("rst_overrun", overrun, 0);
      reset_n = 1'b1;

      // First frame: sample1=i, sample2=-i, every sample stored
      address1 = 12'd5;
      address2 = 12'd5;
      for (int i = 0; i < 1024; i++) begin
         pushPair(i, -i, 1'b0);
         if (i == 512)  check("noFrame_d1", dataOut1, 0);
         if (i == 1022) check("fill_frameReady_before_last", frameReady, 0);
      end
      check("full_frameReady", frameReady, 1);
      check("full_noSwap_d1", dataOut1, 0);
      check("full_noSwap_d2", dataOut2, 0);

      // Swap: read presented in swap cycle sees the old (empty) bank
      drawPulse();
      check("swapCycle_d1", dataOut1, 0);
      check("swap_frameReady", frameReady, 0);
      tick();
      check("postSwap_d1", dataOut1, 5);
      check("postSwap_d2", dataOut2, -5);
      check("postSwap_overrun", overrun, 0);

      addVec(0, 0, 0, 0, "f1_a0");
      addVec(1023, 0, 1023, 0, "f1_last");
      addVec(1023, 1023, 1023, -1023, "f1_lastBoth");
      addVec(1024, 3, 0, -3, "f1_oobA1");
      addVec(4095, 100, 0, -100, "f1_oobMax");
      addVec(512, 511, 512, -511, "f1_indep");
      runVecs();

      // Decimated frame: keep one of every four samples
      decimation = 8'd3;
      address1   = 12'd5;
      address2   = 12'd5;
      for (int i = 0; i < 4096; i++) begin
         pushPair(i, -i, 1'b0);
         if (i == 2000) check("dec_oldFrame_d1", dataOut1, 5);
         if (i == 4094) check("dec_frameReady_before", frameReady, 0);
      end
      check("dec_frameReady", frameReady, 1);
      check("dec_overrun_clear", overrun, 0);

      // Extra samples while full are dropped and flagged
      for (int i = 0; i < 50; i++) pushPair(12'h7FF, 12'h7FF, 1'b0);
      check("ovr_overrun", overrun, 1);
      check("ovr_frameReady", frameReady, 1);
      repeat (3) tick();
      check("ovr_sticky", overrun, 1);
      check("ovr_oldFrame_d1", dataOut1, 5);
      drawPulse();
      check("ovr_clearedBySwap", overrun, 0);
      addVec(0, 0, 3, -3, "dec_k0");
      addVec(1, 1, 7, -7, "dec_k1");
      addVec(500, 500, 2003, -2003, "dec_k500");
      addVec(1022, 1022, s12(4091), s12(-4091), "dec_k1022");
      addVec(1023, 1023, s12(4095), s12(-4095), "dec_k1023");
      addVec(4000, 2, 0, -11, "dec_oob");
      runVecs();

      // Half frame, then drawStarting while filling is ignored
      decimation = 8'd0;
      for (int i = 0; i < 512; i++) pushPair(i + 100, -(i + 100), 1'b0);
      address1 = 12'd0;
      address2 = 12'd0;
      drawPulse();
      tick();
      check("fillDraw_d1", dataOut1, 3);
      check("fillDraw_d2", dataOut2, -3);
      check("fillDraw_frameReady", frameReady, 0);

      // drawStarting on the final write completes the frame without swapping
      for (int i = 512; i < 1024; i++) pushPair(i + 100, -(i + 100), i == 1023);
      check("lastDraw_frameReady", frameReady, 1);
      check("lastDraw_d1", dataOut1, 3);
      tick();
      check("lastDraw_noSwap_d1", dataOut1, 3);
      drawPulse();
      addVec(0, 0, 100, -100, "f3_a0");
      addVec(1023, 1023, 1123, -1123, "f3_last");
      addVec(1024, 1024, 0, 0, "f3_oob");
      addVec(700, 1, 800, -101, "f3_indep");
      runVecs();

      // Reset in the middle of a fill discards the partial frame
      address1 = 12'd0;
      address2 = 12'd0;
      for (int i = 0; i < 500; i++) pushPair(i + 50, -(i + 50), 1'b0);
      check("preRst_d1", dataOut1, 100);
      reset_n = 1'b0;
      #1;
      check("midRst_d1", dataOut1, 0);
      check("midRst_d2", dataOut2, 0);
      check("midRst_frameReady", frameReady, 0);
      check("midRst_overrun", overrun, 0);
      tick();
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         pushPair(i + 7, -(i + 7), 1'b0);
         if (i == 1022) check("refill_frameReady_before", frameReady, 0);
      end
      check("refill_frameReady", frameReady, 1);
      check("refill_noFrame_d1", dataOut1, 0);
      drawPulse();
      addVec(0, 0, 7, -7, "f4_a0");
      addVec(1023, 500, 1030, -507, "f4_mix");
      addVec(1023, 1023, 1030, -1030, "f4_last");
      runVecs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/xy_sample_buffer.md
XY_SAMPLE_BUFFER -- requirements
Module: xy_sample_buffer

Interface
REQ-001 SHALL have parameter DATA_IN_BITS, default 12, sample width (signed, two's complement).
REQ-002 SHALL have parameter ADDRESS_BITS, default 12, read/write address width.
REQ-003 SHALL have parameter DEPTH, default 1024, samples per channel per frame (≤ 2^ADDRESS_BITS).
REQ-004 SHALL have parameter DECIMATE_BITS, default 8, decimation control width.
REQ-005 SHALL have ports, one per line:
  - clock  in  1  sole clock, all logic on rising edge
  - reset_n  in  1  asynchronous, active-low reset
  - sampleValid  in  1  sample1/sample2 valid this cycle
  - sample1  in  DATA_IN_BITS  channel 1 sample, signed (X axis)
  - sample2  in  DATA_IN_BITS  channel 2 sample, signed (Y axis)
  - decimation  in  DECIMATE_BITS  store one of every decimation+1 valid samples
  - drawStarting  in  1  one-cycle pulse from curve stage at end of visible frame
  - address1  in  ADDRESS_BITS  channel 1 read address
  - address2  in  ADDRESS_BITS  channel 2 read address
  - dataOut1  out  DATA_IN_BITS  channel 1 read data, signed
  - dataOut2  out  DATA_IN_BITS  channel 2 read data, signed
  - frameReady  out  1  write bank holds a complete frame awaiting swap
  - overrun  out  1  sticky: stored sample dropped because write bank was full
REQ-006 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-007 SHALL hold two banks per channel (ping-pong), each DEPTH × DATA_IN_BITS: one read bank (display side), one write bank (capture side).
REQ-008 SHALL keep a decimation counter: on each cycle with sampleValid=1, sample stored iff counter == decimation; counter then returns to 0, otherwise increments.
REQ-009 SHALL treat decimation=0 as storing every valid sample.
REQ-010 SHALL, when decimation changes mid-frame, apply the new value at the next compare, with no counter reset.
REQ-011 SHALL implement a two-state FSM: FILL, FULL.
REQ-012 In FILL, SHALL write stored sample pair to the write bank at wrAddr, then increment wrAddr.
REQ-013 SHALL transition FILL→FULL on the write to wrAddr = DEPTH-1; frameReady=1 from the next cycle.
REQ-014 In FULL, SHALL discard stored samples and set overrun=1.
REQ-015 SHALL, on drawStarting=1 in FULL: swap banks, clear wrAddr, decimation counter, frameReady and overrun, and enter FILL next cycle.
REQ-016 SHALL ignore drawStarting in FILL: read bank unchanged, so the display repeats the previous frame.
REQ-017 SHALL, when drawStarting coincides with the final FILL write, complete the write, enter FULL and not swap; the swap waits for the next drawStarting.
REQ-018 SHALL register read data: dataOutN valid one cycle after addressN, from the current read bank.
REQ-019 SHALL make swap-cycle reads (address presented in the drawStarting cycle) return old-bank data; reads from the next cycle return new-bank data.
REQ-020 SHALL return 0 for addressN ≥ DEPTH (no wrap).
REQ-021 SHALL force dataOut1/dataOut2 to 0 until the first swap after reset (no valid frame yet).
REQ-022 SHALL decode address1 and address2 independently; equal addresses are legal.

Reset
REQ-023 SHALL on reset_n=0 immediately set: FILL, wrAddr=0, decimation counter=0, read bank select=0, frameReady=0, overrun=0, dataOut1=dataOut2=0, valid-frame flag=0.
REQ-024 SHALL leave RAM contents unreset; REQ-021 masks them.
REQ-025 SHALL, on reset mid-FILL, discard the partial frame; capture restarts at wrAddr 0 after release.

Structure
REQ-026 SHALL place DATA_IN_BITS, ADDRESS_BITS and DEPTH defaults in the shared scope package used by the curve stage, so producer and consumer widths match.
REQ-027 SHALL place FSM state encoding (FILL, FULL) in that package.
REQ-028 SHALL instantiate sub-module sample_bank_ram (one write port, one registered read port, DEPTH × DATA_IN_BITS) four times: 2 channels × 2 banks.

Verification
REQ-029 Reset release, decimation=0, 1024 valid pairs (sample1=i, sample2=-i) → frameReady=1 after write 1023; dataOut stays 0 before drawStarting.
REQ-030 drawStarting pulse in FULL, then address1=address2=5 → one cycle later dataOut1=5, dataOut2=-5; frameReady=0 and overrun=0 after swap.
REQ-031 decimation=3, 4096 consecutive valid samples with value i → stored entry k = 4k+3; FULL reached on input 4095.
REQ-032 50 extra valid samples in FULL → overrun=1, bank contents unchanged; drawStarting in FILL (half-full) → no swap, dataOut still previous frame.
REQ-033 drawStarting on the same cycle as write 1023 → no swap, FULL entered; next drawStarting swaps; address1=1024 → dataOut1=0.
REQ-034 reset_n pulsed low at wrAddr=500 → all outputs 0 within the reset cycle; refill from 0 and first swap give correct data.
